// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default sizing for the fetch stage.
//   fetch_state_t - sequencer state encoding (IDLE, RUN, DONE)
//   PC_W          - program-counter width (imem depth 2^PC_W)
//   LUT_AW        - branch-target LUT address width
//   CNT_W         - retired-instruction counter width
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/branch_lut.sv
// branch_lut: programmable branch-target table.
//   clk, reset - clock and synchronous active-high reset (clears all entries)
//   we, waddr, wdata - synchronous write port
//   raddr, rdata     - asynchronous read port
// A read of an entry being written in the same cycle returns the old value;
// the new value appears after the clock edge.
module branch_lut #(
  parameter int AW = 4,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program counter and fetch sequencer.
//   clk, reset      - clock, synchronous active-high reset
//   start, start_addr - begin execution at start_addr (accepted in IDLE/DONE)
//   jen, brc_j, br_en - ALU jump flag, branch compare (0 = holds), branch decode
//   halt, tgt_idx   - halt decode, branch-target LUT index
//   lut_we, lut_waddr, lut_wdata - LUT programming port
//   prog_ctr        - registered PC to instruction memory
//   running, done   - in RUN / in DONE
//   retired         - saturating count of RUN cycles since last start
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | fetching; PC advances or redirects every cycle
// DONE  | halt seen; PC parked on halt instruction, waiting for start
module fetch_ctrl #(
  parameter int PC_W   = fetch_pkg::PC_W,
  parameter int LUT_AW = fetch_pkg::LUT_AW,
  parameter int CNT_W  = fetch_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              jen,
  input  logic              brc_j,
  input  logic              br_en,
  input  logic              halt,
  input  logic [LUT_AW-1:0] tgt_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   prog_ctr,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  retired
);

  import fetch_pkg::*;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_tgt;
  logic             taken;

  branch_lut #(
    .AW (LUT_AW),
    .DW (PC_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (tgt_idx),
    .rdata (lut_tgt)
  );

  // brc_j is active-low: 0 means the branch condition holds
  assign taken = jen | (br_en & ~brc_j);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // the halt cycle retires too
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // halt wins over redirect and parks the PC on the halt instruction
        if (halt) begin
          state_d = DONE;
        end else if (taken) begin
          pc_d = lut_tgt;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign prog_ctr = pc_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign retired  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int PW = 10;
  localparam int AW = 4;
  localparam int CW = 4;   // narrow counter so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, jen, brc_j, br_en, halt, lut_we;
  logic [PW-1:0] start_addr, lut_wdata;
  logic [AW-1:0] tgt_idx, lut_waddr;
  logic [PW-1:0] prog_ctr;
  logic          running, done;
  logic [CW-1:0] retired;

  int checks = 0;
  int passes = 0;

  // reference model: plain integers, rules applied directly
  int m_pc, m_ret, m_lut[16];
  bit m_run, m_done;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(PW), .LUT_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .jen(jen), .brc_j(brc_j), .br_en(br_en), .halt(halt), .tgt_idx(tgt_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .running(running), .done(done), .retired(retired)
  );

  task automatic clear_inputs();
    reset = 0; start = 0; jen = 0; brc_j = 1; br_en = 0; halt = 0;
    lut_we = 0; start_addr = '0; lut_wdata = '0; tgt_idx = '0; lut_waddr = '0;
  endtask

  // one clock edge; model advances on the same sampled inputs, outputs read 1 ns later
  task automatic tick();
    int old_tgt;
    @(posedge clk);
    old_tgt = m_lut[tgt_idx];
    if (reset) begin
      m_pc = 0; m_ret = 0; m_run = 0; m_done = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
    end else begin
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_done = 0; m_pc = start_addr; m_ret = 0;
        end
      end else begin
        if (m_ret < CMAX) m_ret = m_ret + 1;
        if (halt) begin
          m_run = 0; m_done = 1;
        end else if (jen || (br_en && !brc_j)) begin
          m_pc = old_tgt;
        end else begin
          m_pc = (m_pc + 1) % (1 << PW);
        end
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
    end
    #1;
  endtask

  task automatic lut_write(input int idx, input int val);
    lut_we = 1; lut_waddr = AW'(idx); lut_wdata = PW'(val);
    tick();
    lut_we = 0;
  endtask

  // halts if currently running, then starts at addr
  task automatic start_at(input int addr);
    if (running) begin
      halt = 1; tick(); halt = 0;
    end
    start = 1; start_addr = PW'(addr);
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; start = 1; lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h155;
    tick();
    tick();
    clear_inputs();
    checks++;
    if (prog_ctr !== 10'h000 || running !== 1'b0 || done !== 1'b0 || retired !== 4'd0)
      $display("FAIL reset_state: pc=%h run=%b done=%b ret=%0d want 000/0/0/0", prog_ctr, running, done, retired);
    else passes++;
  endtask

  task automatic test_sequential();
    logic [PW-1:0] want;
    start_at(5);
    checks++;
    if (prog_ctr !== 10'h005 || running !== 1'b1)
      $display("FAIL seq_start: pc=%h run=%b want 005/1", prog_ctr, running);
    else passes++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      want = PW'(5 + i);
      checks++;
      if (prog_ctr !== want) $display("FAIL seq_step%0d: pc=%h want %h", i, prog_ctr, want);
      else passes++;
    end
    checks++;
    if (retired !== 4'd4) $display("FAIL seq_retired: got %0d want 4", retired);
    else passes++;
  endtask

  task automatic test_jump();
    lut_write(3, 'h120);
    start_at('h010);
    jen = 1; tgt_idx = 3;
    tick();
    jen = 0;
    checks++;
    if (prog_ctr !== 10'h120) $display("FAIL jump_jen: pc=%h want 120", prog_ctr);
    else passes++;
    start_at('h010);
    br_en = 1; brc_j = 1; tgt_idx = 3;
    tick();
    checks++;
    if (prog_ctr !== 10'h011) $display("FAIL br_not_taken: pc=%h want 011", prog_ctr);
    else passes++;
    brc_j = 0;
    tick();
    br_en = 0; brc_j = 1;
    checks++;
    if (prog_ctr !== 10'h120) $display("FAIL br_taken: pc=%h want 120", prog_ctr);
    else passes++;
  endtask

  task automatic test_wrap();
    start_at('h3FF);
    tick();
    checks++;
    if (prog_ctr !== 10'h000) $display("FAIL pc_wrap: pc=%h want 000", prog_ctr);
    else passes++;
  endtask

  task automatic test_halt();
    start_at('h040);
    halt = 1; jen = 1; tgt_idx = 3;
    tick();
    halt = 0;
    checks++;
    if (prog_ctr !== 10'h040 || done !== 1'b1 || running !== 1'b0 || retired !== 4'd1)
      $display("FAIL halt: pc=%h done=%b run=%b ret=%0d want 040/1/0/1", prog_ctr, done, running, retired);
    else passes++;
    tick();   // jen still high: must be ignored outside RUN
    jen = 0;
    checks++;
    if (prog_ctr !== 10'h040 || done !== 1'b1)
      $display("FAIL done_hold: pc=%h done=%b want 040/1", prog_ctr, done);
    else passes++;
    start_at(0);
    checks++;
    if (prog_ctr !== 10'h000 || done !== 1'b0 || retired !== 4'd0 || running !== 1'b1)
      $display("FAIL restart: pc=%h done=%b ret=%0d run=%b want 000/0/0/1", prog_ctr, done, retired, running);
    else passes++;
  endtask

  task automatic test_back_to_back_lut();
    lut_write(2, 'h055);
    start_at('h030);
    lut_we = 1; lut_waddr = 2; lut_wdata = 10'h0AA;
    jen = 1; tgt_idx = 2;
    tick();
    lut_we = 0;
    checks++;
    if (prog_ctr !== 10'h055) $display("FAIL lut_old_read: pc=%h want 055", prog_ctr);
    else passes++;
    tick();
    jen = 0;
    checks++;
    if (prog_ctr !== 10'h0AA) $display("FAIL lut_new_read: pc=%h want 0aa", prog_ctr);
    else passes++;
  endtask

  task automatic test_saturate();
    start_at('h200);
    repeat (CMAX + 5) tick();
    checks++;
    if (retired !== CW'(CMAX)) $display("FAIL saturate: got %0d want %0d", retired, CMAX);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    start_at('h06E);
    repeat (9) tick();
    checks++;
    if (prog_ctr !== 10'h077 || retired !== 4'd9)
      $display("FAIL pre_abort: pc=%h ret=%0d want 077/9", prog_ctr, retired);
    else passes++;
    reset = 1; start = 1; start_addr = 10'h123;
    tick();
    reset = 0; start = 0;
    checks++;
    if (prog_ctr !== 10'h000 || retired !== 4'd0 || running !== 1'b0 || done !== 1'b0)
      $display("FAIL abort: pc=%h ret=%0d run=%b done=%b want 000/0/0/0", prog_ctr, retired, running, done);
    else passes++;
    tick();
    checks++;
    if (running !== 1'b0 || prog_ctr !== 10'h000)
      $display("FAIL abort_idle: run=%b pc=%h want 0/000", running, prog_ctr);
    else passes++;
    start_at('h100);
    jen = 1; tgt_idx = 3;   // entry 3 held 0x120 before reset
    tick();
    jen = 0;
    checks++;
    if (prog_ctr !== 10'h000) $display("FAIL lut_cleared: pc=%h want 000", prog_ctr);
    else passes++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 9) == 0);
      start_addr = PW'($urandom);
      jen        = ($urandom_range(0, 5) == 0);
      br_en      = ($urandom_range(0, 3) == 0);
      brc_j      = $urandom_range(0, 1) != 0;
      halt       = ($urandom_range(0, 19) == 0);
      tgt_idx    = AW'($urandom);
      lut_we     = ($urandom_range(0, 3) == 0);
      lut_waddr  = AW'($urandom);
      lut_wdata  = PW'($urandom);
      tick();
      checks++;
      if (prog_ctr !== PW'(m_pc) || running !== m_run || done !== m_done || retired !== CW'(m_ret)) begin
        if (errs < 10)
          $display("FAIL random[%0d]: pc=%h run=%b done=%b ret=%0d want pc=%h run=%b done=%b ret=%0d",
                   n, prog_ctr, running, done, retired, PW'(m_pc), m_run, m_done, m_ret);
        errs++;
      end else passes++;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_wrap();
    test_halt();
    test_back_to_back_lut();
    test_saturate();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
